// File: rtl/atm_txn_sequencer.sv
// Account-RAM transaction sequencer: read/check/write for balance, withdraw,
// deposit and transfer, plus the saturating cash-in-machine register.
module atm_txn_sequencer #(
  parameter int CREDIT_VAL_SIZE = 25,
  parameter int UP_LIMIT_SIZE   = 15,
  parameter int RAM_DATA_WIDTH  = UP_LIMIT_SIZE + CREDIT_VAL_SIZE,
  parameter int DEPTH           = 64,
  parameter int ADDR_W          = $clog2(DEPTH),
  parameter int OP_CHOICE_SIZE  = 2,
  parameter int WITHDRAW_SIZE   = 15,
  parameter int ATM_CAP_SIZE    = 18,
  parameter int ATM_CAP_INIT    = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [OP_CHOICE_SIZE-1:0]  req_op,
  input  logic [ADDR_W-1:0]          req_acct,
  input  logic [ADDR_W-1:0]          req_dst,
  input  logic [WITHDRAW_SIZE-1:0]   req_amount,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [RAM_DATA_WIDTH-1:0]  ram_wdata,
  input  logic [RAM_DATA_WIDTH-1:0]  ram_rdata,
  output logic                       rsp_valid,
  output logic [1:0]                 rsp_status,
  output logic [CREDIT_VAL_SIZE-1:0] rsp_balance,
  input  logic                       cash_load_valid,
  input  logic [ATM_CAP_SIZE-1:0]    cash_load_amount,
  output logic [ATM_CAP_SIZE-1:0]    atm_cash
);

  localparam logic [OP_CHOICE_SIZE-1:0] OP_BAL  = 2'b00;
  localparam logic [OP_CHOICE_SIZE-1:0] OP_WD   = 2'b01;
  localparam logic [OP_CHOICE_SIZE-1:0] OP_DEP  = 2'b10;
  localparam logic [OP_CHOICE_SIZE-1:0] OP_XFER = 2'b11;
  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_CREDIT = 2'b01;
  localparam logic [1:0] ST_LIMIT  = 2'b10;
  localparam logic [1:0] ST_CASH   = 2'b11;
  localparam logic [ATM_CAP_SIZE-1:0] CASH_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_CAP1, S_RD2, S_CAP2, S_WR1, S_WR2, S_RESP
  } state_t;

  state_t                       r_state;
  logic [OP_CHOICE_SIZE-1:0]    r_op;
  logic [ADDR_W-1:0]            r_acct;
  logic [ADDR_W-1:0]            r_dst;
  logic [WITHDRAW_SIZE-1:0]     r_amount;
  logic [RAM_DATA_WIDTH-1:0]    r_src_word;
  logic [RAM_DATA_WIDTH-1:0]    r_dst_word;
  logic [CREDIT_VAL_SIZE-1:0]   r_pend_bal;
  logic [ATM_CAP_SIZE-1:0]      r_cash;
  logic                         r_req_ready;
  logic                         r_ram_en;
  logic                         r_ram_we;
  logic [ADDR_W-1:0]            r_ram_addr;
  logic [RAM_DATA_WIDTH-1:0]    r_ram_wdata;
  logic                         r_rsp_valid;
  logic [1:0]                   r_rsp_status;
  logic [CREDIT_VAL_SIZE-1:0]   r_rsp_balance;

  logic [CREDIT_VAL_SIZE-1:0]   w_rd_credit;
  logic [UP_LIMIT_SIZE-1:0]     w_rd_limit;
  logic [CREDIT_VAL_SIZE-1:0]   w_amt_c;
  logic [CREDIT_VAL_SIZE:0]     w_rd_sum;
  logic [CREDIT_VAL_SIZE-1:0]   w_rd_diff;
  logic [CREDIT_VAL_SIZE-1:0]   w_src_diff;
  logic                         w_over_credit;
  logic                         w_over_limit;
  logic                         w_over_cash;
  logic                         w_dep_over;
  logic                         w_same_acct;
  logic                         w_fail;
  logic [1:0]                   w_fail_code;
  logic [ATM_CAP_SIZE+1:0]      w_load_ext;
  logic [ATM_CAP_SIZE+1:0]      w_amt_cash;
  logic [ATM_CAP_SIZE+1:0]      w_cash_sum;
  logic [ATM_CAP_SIZE-1:0]      w_cash_next;

  assign w_rd_credit   = ram_rdata[CREDIT_VAL_SIZE-1:0];
  assign w_rd_limit    = ram_rdata[RAM_DATA_WIDTH-1:CREDIT_VAL_SIZE];
  assign w_amt_c       = CREDIT_VAL_SIZE'(r_amount);
  assign w_rd_sum      = {1'b0, w_rd_credit} + {1'b0, w_amt_c};
  assign w_rd_diff     = w_rd_credit - w_amt_c;
  assign w_src_diff    = r_src_word[CREDIT_VAL_SIZE-1:0] - w_amt_c;
  assign w_over_credit = w_amt_c > w_rd_credit;
  assign w_over_limit  = w_amt_c > CREDIT_VAL_SIZE'(w_rd_limit);
  assign w_over_cash   = (ATM_CAP_SIZE+1)'(r_amount) > {1'b0, r_cash};
  assign w_dep_over    = ({1'b0, r_cash} + (ATM_CAP_SIZE+1)'(r_amount)) > {1'b0, CASH_MAX};
  assign w_same_acct   = r_acct == r_dst;
  assign w_load_ext    = cash_load_valid ? {2'b00, cash_load_amount} : '0;
  assign w_amt_cash    = (ATM_CAP_SIZE+2)'(r_amount);

  // CAP1 check outcome for the source word, in status priority order
  always_comb begin
    w_fail      = 1'b0;
    w_fail_code = ST_OK;
    case (r_op)
      OP_WD: begin
        if (w_over_credit)     begin w_fail = 1'b1; w_fail_code = ST_CREDIT; end
        else if (w_over_limit) begin w_fail = 1'b1; w_fail_code = ST_LIMIT;  end
        else if (w_over_cash)  begin w_fail = 1'b1; w_fail_code = ST_CASH;   end
        else                   begin w_fail = 1'b0; w_fail_code = ST_OK;     end
      end
      OP_DEP: begin
        if (w_rd_sum[CREDIT_VAL_SIZE]) begin w_fail = 1'b1; w_fail_code = ST_LIMIT; end
        else if (w_dep_over)           begin w_fail = 1'b1; w_fail_code = ST_CASH;  end
        else                           begin w_fail = 1'b0; w_fail_code = ST_OK;    end
      end
      OP_XFER: begin
        if (w_same_acct)       begin w_fail = 1'b0; w_fail_code = ST_OK;     end
        else if (w_over_credit) begin w_fail = 1'b1; w_fail_code = ST_CREDIT; end
        else if (w_over_limit) begin w_fail = 1'b1; w_fail_code = ST_LIMIT;  end
        else                   begin w_fail = 1'b0; w_fail_code = ST_OK;     end
      end
      default: begin
        w_fail      = 1'b0;
        w_fail_code = ST_OK;
      end
    endcase
  end

  // Cash register next value: refill and the WR1 cash movement land together, then saturate
  always_comb begin
    w_cash_sum = {2'b00, r_cash} + w_load_ext;
    if (r_state == S_WR1 && r_op == OP_WD) begin
      w_cash_sum = w_cash_sum - w_amt_cash;
    end else if (r_state == S_WR1 && r_op == OP_DEP) begin
      w_cash_sum = w_cash_sum + w_amt_cash;
    end else begin
      w_cash_sum = {2'b00, r_cash} + w_load_ext;
    end
  end

  assign w_cash_next = (w_cash_sum > {2'b00, CASH_MAX}) ? CASH_MAX : w_cash_sum[ATM_CAP_SIZE-1:0];

  // Sequencer FSM with registered RAM and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_acct        <= '0;
      r_dst         <= '0;
      r_amount      <= '0;
      r_src_word    <= '0;
      r_dst_word    <= '0;
      r_pend_bal    <= '0;
      r_cash        <= ATM_CAP_SIZE'(ATM_CAP_INIT);
      r_req_ready   <= 1'b1;
      r_ram_en      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_wdata   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_status  <= 2'b00;
      r_rsp_balance <= '0;
    end else begin
      r_cash      <= w_cash_next;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op        <= req_op;
            r_acct      <= req_acct;
            r_dst       <= req_dst;
            r_amount    <= req_amount;
            r_ram_en    <= 1'b1;
            r_ram_addr  <= req_acct;
            r_req_ready <= 1'b0;
            r_state     <= S_RD1;
          end
        end
        S_RD1: r_state <= S_CAP1;
        S_CAP1: begin
          r_src_word <= ram_rdata;
          if (w_fail || r_op == OP_BAL || (r_op == OP_XFER && w_same_acct)) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_status  <= w_fail_code;
            r_rsp_balance <= w_rd_credit;
            r_state       <= S_RESP;
          end else if (r_op == OP_XFER) begin
            r_ram_en   <= 1'b1;
            r_ram_addr <= r_dst;
            r_state    <= S_RD2;
          end else begin
            r_ram_en    <= 1'b1;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= r_acct;
            r_ram_wdata <= {w_rd_limit, (r_op == OP_WD) ? w_rd_diff : w_rd_sum[CREDIT_VAL_SIZE-1:0]};
            r_pend_bal  <= (r_op == OP_WD) ? w_rd_diff : w_rd_sum[CREDIT_VAL_SIZE-1:0];
            r_state     <= S_WR1;
          end
        end
        S_RD2: r_state <= S_CAP2;
        S_CAP2: begin
          if (w_rd_sum[CREDIT_VAL_SIZE]) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_status  <= ST_LIMIT;
            r_rsp_balance <= r_src_word[CREDIT_VAL_SIZE-1:0];
            r_state       <= S_RESP;
          end else begin
            r_dst_word  <= {w_rd_limit, w_rd_sum[CREDIT_VAL_SIZE-1:0]};
            r_ram_en    <= 1'b1;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= r_acct;
            r_ram_wdata <= {r_src_word[RAM_DATA_WIDTH-1:CREDIT_VAL_SIZE], w_src_diff};
            r_pend_bal  <= w_src_diff;
            r_state     <= S_WR1;
          end
        end
        S_WR1: begin
          if (r_op == OP_XFER) begin
            r_ram_en    <= 1'b1;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= r_dst;
            r_ram_wdata <= r_dst_word;
            r_state     <= S_WR2;
          end else begin
            r_rsp_valid   <= 1'b1;
            r_rsp_status  <= ST_OK;
            r_rsp_balance <= r_pend_bal;
            r_state       <= S_RESP;
          end
        end
        S_WR2: begin
          r_rsp_valid   <= 1'b1;
          r_rsp_status  <= ST_OK;
          r_rsp_balance <= r_pend_bal;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign ram_en      = r_ram_en;
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_status  = r_rsp_status;
  assign rsp_balance = r_rsp_balance;
  assign atm_cash    = r_cash;

endmodule

// File: tb/tb_atm_txn_sequencer.sv
// Bench for atm_txn_sequencer: behavioural RAM, spec-level account/cash model,
// per-cycle compare process and directed vectors with literal pins.
module tb_atm_txn_sequencer;
  localparam int CMAX = 33554431;
  localparam int KMAX = 262143;
  localparam int INIT = 100000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [5:0]  req_acct;
  logic [5:0]  req_dst;
  logic [14:0] req_amount;
  logic        ram_en;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [39:0] ram_wdata;
  logic [39:0] ram_rdata = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [24:0] rsp_balance;
  logic        cash_load_valid;
  logic [17:0] cash_load_amount;
  logic [17:0] atm_cash;

  atm_txn_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_acct(req_acct), .req_dst(req_dst), .req_amount(req_amount),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance), .cash_load_valid(cash_load_valid),
    .cash_load_amount(cash_load_amount), .atm_cash(atm_cash)
  );

  always #5 clk = ~clk;

  logic [39:0] mem [64];
  logic [39:0] ref_mem [64];
  logic        ld_en = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [39:0] ld_data = '0;
  int wr_count = 0;
  int cyc = 0;
  int exp_rsp_cyc = -1;
  int busy_lo = -1;
  int busy_hi = -1;
  int pend_cyc = -1;
  int pend_delta = 0;
  int exp_status = 0;
  int exp_bal = 0;
  int ref_cash = INIT;
  int tests = 0;
  int fails = 0;
  logic run_chk = 1'b0;
  logic [1:0]  last_st = '0;
  logic [24:0] last_bal = '0;

  // single-port synchronous account RAM, with a bench-side preload port
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  always @(posedge clk) begin
    if (ram_en && ram_we) wr_count <= wr_count + 1;
  end

  function automatic int sat(input int v);
    return (v > KMAX) ? KMAX : v;
  endfunction

  function automatic logic [39:0] mk(input int lim, input int cr);
    logic [14:0] l;
    logic [24:0] c;
    l = lim[14:0];
    c = cr[24:0];
    return {l, c};
  endfunction

  // reference cash: refills every cycle, op movement at the end of the write cycle
  always @(posedge clk) begin
    if (!rst_n) ref_cash <= INIT;
    else ref_cash <= sat(ref_cash + (cash_load_valid ? int'(cash_load_amount) : 0)
                         + ((cyc == pend_cyc) ? pend_delta : 0));
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && run_chk) begin
      chk("rsp_valid", rsp_valid, cyc == exp_rsp_cyc);
      if (cyc == exp_rsp_cyc) begin
        chk("rsp_status", rsp_status, exp_status);
        chk("rsp_balance", rsp_balance, exp_bal);
      end
      chk("req_ready", req_ready, !(cyc >= busy_lo && cyc <= busy_hi));
      chk("atm_cash", atm_cash, ref_cash);
      if (rsp_valid) begin
        last_st  <= rsp_status;
        last_bal <= rsp_balance;
      end
    end
  end

  // outcome of one operation from the account rules
  task automatic model(input int op, input int a, input int d, input int amt,
                       output int st, output int bal, output int lat, output int nw,
                       output int delta, output logic [39:0] ns, output logic [39:0] nd);
    int cr, lim, dcr;
    cr = int'(ref_mem[a][24:0]);
    lim = int'(ref_mem[a][39:25]);
    dcr = int'(ref_mem[d][24:0]);
    ns = ref_mem[a]; nd = ref_mem[d];
    st = 0; bal = cr; lat = 3; nw = 0; delta = 0;
    case (op)
      1: if (amt > cr) st = 1; else if (amt > lim) st = 2; else if (amt > ref_cash) st = 3;
         else begin bal = cr - amt; lat = 4; nw = 1; delta = -amt; ns[24:0] = bal[24:0]; end
      2: if (cr + amt > CMAX) st = 2; else if (ref_cash + amt > KMAX) st = 3;
         else begin bal = cr + amt; lat = 4; nw = 1; delta = amt; ns[24:0] = bal[24:0]; end
      3: if (a == d) st = 0; else if (amt > cr) st = 1; else if (amt > lim) st = 2;
         else if (dcr + amt > CMAX) begin st = 2; lat = 5; end
         else begin bal = cr - amt; lat = 7; nw = 2; ns[24:0] = bal[24:0]; nd[24:0] = 25'(dcr + amt); end
      default: st = 0;
    endcase
  endtask

  task automatic do_op(input int op, input int a, input int d, input int amt, input int ld);
    int st, bal, lat, nw, delta, t, w0;
    logic [39:0] ns, nd;
    model(op, a, d, amt, st, bal, lat, nw, delta, ns, nd);
    @(posedge clk); #1;
    t = cyc;
    req_valid = 1'b1; req_op = op[1:0]; req_acct = a[5:0]; req_dst = d[5:0]; req_amount = amt[14:0];
    exp_status = st; exp_bal = bal; exp_rsp_cyc = t + lat; busy_lo = t + 1; busy_hi = t + lat;
    pend_delta = delta; pend_cyc = (nw == 1) ? t + 3 : -1;
    w0 = wr_count;
    while (cyc < t + lat + 1) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      cash_load_valid = (ld > 0) && (cyc == t + 3);
      cash_load_amount = ld[17:0];
    end
    cash_load_valid = 1'b0;
    chk("ram_writes", wr_count - w0, nw);
    ref_mem[d] = nd;
    ref_mem[a] = ns;
    chk("ram_src", mem[a], ref_mem[a]);
    chk("ram_dst", mem[d], ref_mem[d]);
  endtask

  task automatic cash_load(input int amt);
    @(posedge clk); #1;
    cash_load_valid = 1'b1; cash_load_amount = amt[17:0];
    @(posedge clk); #1;
    cash_load_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_rsp_cyc = -1; busy_lo = -1; busy_hi = -1; pend_cyc = -1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  task automatic preload(input int a, input int lim, input int cr);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = a[5:0]; ld_data = mk(lim, cr);
    ref_mem[a] = mk(lim, cr);
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  initial begin
    int t, w0;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_acct = '0; req_dst = '0;
    req_amount = '0; cash_load_valid = 1'b0; cash_load_amount = '0;
    preload(5, 2000, 5000);
    preload(3, 1000, 1000);
    preload(9, 500, 200);
    preload(7, 1000, CMAX - 49);
    preload(8, 1000, 0);
    preload(10, 32767, 200000);
    @(negedge clk);
    chk("rst_atm_cash", atm_cash, 100000);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ram_en", {ram_en, ram_we}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rsp", {rsp_status, rsp_balance}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_chk = 1'b1;

    do_op(1, 5, 5, 1500, 0);
    chk("wd_ok_bal", last_bal, 3500);
    chk("wd_ok_ram", mem[5][24:0], 3500);
    chk("wd_ok_cash", atm_cash, 98500);
    do_op(1, 5, 5, 2500, 0);
    chk("wd_limit", last_st, 2);
    do_op(1, 5, 5, 6000, 0);
    chk("wd_credit", last_st, 1);
    do_op(2, 7, 7, 100, 0);
    chk("dep_ovf", last_st, 2);
    do_op(2, 8, 8, 100, 0);
    chk("dep_ok_bal", last_bal, 100);
    chk("dep_ok_cash", atm_cash, 98600);
    do_op(0, 5, 5, 0, 0);
    chk("bal_op", last_bal, 3500);
    do_op(3, 3, 9, 700, 0);
    chk("xfer_bal", last_bal, 300);
    chk("xfer_dst_ram", mem[9][24:0], 900);
    do_op(3, 3, 3, 200, 0);
    chk("xfer_same", {last_st, last_bal}, 300);
    do_op(3, 3, 7, 100, 0);
    chk("xfer_dst_ovf", last_st, 2);

    do_reset();
    do_op(1, 5, 5, 1500, 50);
    chk("wd_with_load", atm_cash, 98550);
    chk("wd_with_load_bal", last_bal, 2000);
    cash_load(200000);
    chk("load_sat", atm_cash, 262143);
    do_op(2, 8, 8, 100, 0);
    chk("dep_cash_full", last_st, 3);

    do_reset();
    repeat (3) do_op(1, 10, 10, 32767, 0);
    do_op(1, 10, 10, 699, 0);
    chk("drained_cash", atm_cash, 1000);
    do_op(1, 10, 10, 1500, 0);
    chk("wd_cash_short", last_st, 3);

    // transfer aborted by reset in its first write cycle
    @(posedge clk); #1;
    t = cyc;
    req_valid = 1'b1; req_op = 2'b11; req_acct = 6'd3; req_dst = 6'd9; req_amount = 15'd50;
    exp_rsp_cyc = t + 7; busy_lo = t + 1; busy_hi = t + 7;
    w0 = wr_count;
    while (cyc < t + 5) begin @(posedge clk); #1; req_valid = 1'b0; end
    rst_n = 1'b0;
    exp_rsp_cyc = -1; busy_lo = -1; busy_hi = -1;
    @(negedge clk);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_cash", atm_cash, 100000);
    chk("abort_ready", req_ready, 1);
    chk("abort_we", ram_we, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("abort_writes", wr_count - w0, 0);
    chk("abort_src", mem[3], ref_mem[3]);
    chk("abort_dst", mem[9], ref_mem[9]);
    do_op(0, 3, 3, 0, 0);
    chk("post_abort_bal", last_bal, 300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/atm_txn_sequencer.md
# atm_txn_sequencer

Transaction sequencer between the ATM front-end FSM and the account RAM (DEPTH words of {up_limit, credit}). Accepts one operation at a time (balance, withdraw, deposit, transfer) and performs the read/check/write sequence on the single-port synchronous RAM. Owns the ATM cash-in-machine register. Returns a one-cycle status/balance response.

## Interface
- CREDIT_VAL_SIZE, 25, credit field width (RAM bits [24:0])
- UP_LIMIT_SIZE, 15, per-transaction limit field width (RAM bits [39:25])
- RAM_DATA_WIDTH, UP_LIMIT_SIZE+CREDIT_VAL_SIZE (40), RAM word width
- DEPTH, 64, accounts; ADDR_W = $clog2(DEPTH) = 6
- OP_CHOICE_SIZE, 2, opcode width
- WITHDRAW_SIZE, 15, amount width (shared by all ops)
- ATM_CAP_SIZE, 18, cash register width
- ATM_CAP_INIT, 100000, cash register reset value
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  high only in IDLE
- req_op  in  2  00 balance, 01 withdraw, 10 deposit, 11 transfer
- req_acct  in  ADDR_W  source/own account
- req_dst  in  ADDR_W  transfer destination (ignored otherwise)
- req_amount  in  WITHDRAW_SIZE  amount
- ram_en, ram_we  out  1  RAM enable / write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  RAM_DATA_WIDTH  write data
- ram_rdata  in  RAM_DATA_WIDTH  read data, valid the cycle after a read
- rsp_valid  out  1  one-cycle response pulse
- rsp_status  out  2  00 OK, 01 insufficient credit, 10 limit/overflow, 11 ATM cash
- rsp_balance  out  CREDIT_VAL_SIZE  source credit after op (unchanged on failure)
- cash_load_valid  in  1  refill strobe
- cash_load_amount  in  ATM_CAP_SIZE  refill amount
- atm_cash  out  ATM_CAP_SIZE  current cash in machine

## Operation
- States: IDLE, RD1, CAP1, RD2, CAP2, WR1, WR2, RESP.
- IDLE: on req_valid&&req_ready latch op/acct/dst/amount, go RD1.
- RD1: ram_en=1, ram_we=0, addr=acct -> CAP1. CAP1: capture ram_rdata as src word.
- Balance: CAP1 -> RESP, status 00.
- Withdraw checks in priority: amount > credit -> 01; amount > up_limit -> 10; amount > atm_cash -> 11. Pass: WR1 writes {up_limit, credit-amount}, atm_cash -= amount.
- Deposit: credit+amount > 2^25-1 -> 10; atm_cash+amount > 2^18-1 -> 11; pass: WR1 writes credit+amount, atm_cash += amount. Sums computed one bit wider.
- Transfer: CAP1 checks 01 then 10 on src; pass -> RD2 (addr=dst) -> CAP2; dst credit+amount overflow -> 10. Pass: WR1 src -= amount, WR2 dst += amount. atm_cash untouched. acct==dst: status 00, no RD2/writes, balance unchanged.
- Any failure: no RAM write, no atm_cash change, go RESP.
- up_limit field never modified by this block.
- RESP: rsp_valid=1 one cycle, then IDLE.
- Cash load: any cycle, atm_cash += cash_load_amount, saturating at 2^18-1. Same cycle as WR1 withdraw/deposit: both applied (atm_cash ± amount + load, saturated).

## Timing
- Reset: state IDLE, atm_cash=ATM_CAP_INIT, ram_en/ram_we/rsp_valid=0, ram_addr/ram_wdata/rsp_status/rsp_balance=0, req_ready=1.
- Accept at cycle T. Balance/any failure in CAP1: rsp_valid at T+3. Withdraw/deposit OK: T+4. Transfer fail in CAP2: T+5. Transfer OK: T+7.
- rsp_status/rsp_balance registered, valid only with rsp_valid; hold until next response.
- req_ready low from T+1 until the cycle after RESP; requests then ignored.
- Reset mid-operation: abort immediately, no further RAM writes; transfer reset between WR1 and WR2 loses the dst credit (accepted, documented).

## Test plan
- acct 5 = {limit 2000, credit 5000}, withdraw 1500 -> T+4 status 00, balance 3500, RAM[5] credit 3500, atm_cash 98500.
- Same account, withdraw 2500 -> status 10, no RAM write; withdraw 6000 -> status 01; atm_cash 1000 & withdraw 1500 -> status 11.
- Deposit 100 into credit 2^25-50 -> status 10, no write; deposit 100 into 0 -> status 00, balance 100, atm_cash +100.
- Transfer 700 from acct 3 (credit 1000) to acct 9 (credit 200) -> T+7 status 00, balance 300, RAM[9] credit 900; acct==dst -> status 00, no write.
- cash_load 50 at WR1 of a 1500 withdraw with atm_cash 100000 -> atm_cash 98550; load 200000 -> saturates 262143.
- Assert rst_n low at WR1 of transfer -> no writes, rsp_valid 0, atm_cash=ATM_CAP_INIT, req_ready 1.
